sram_1r1w_strb: RTL and testbench

Parametrised simple-dual-port RAM: one read port and one write port with per-byte write strobes, registered read data with a valid flag, and a hardware clear sequencer that zeroes the array one word per cycle after reset. It replaces the single-port RAM in the core's small storage structures (register-file-like tables, cache tag/data arrays) where a read and a write must happen in the same cycle and partial-word stores are needed.

---
 rtl/sram_1r1w_strb_if.sv | 33 +++
 rtl/sram_1r1w_strb.sv | 110 +++++++++++
 tb/tb_sram_1r1w_strb.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sram_1r1w_strb_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_1r1w_strb_if
//  Description : Request/response bundle for the strobed 1R1W RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_1r1w_strb_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 64
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                      init_busy;
    logic                      ren;
    logic [ADDR_W-1:0]         raddr;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      rvalid;
    logic                      wen;
    logic [ADDR_W-1:0]         waddr;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic [DATA_WIDTH-1:0]     wdata;

    modport master (
        input  init_busy, rdata, rvalid,
        output ren, raddr, wen, waddr, wstrb, wdata
    );

    modport slave (
        output init_busy, rdata, rvalid,
        input  ren, raddr, wen, waddr, wstrb, wdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_1r1w_strb.sv
`default_nettype none
// ============================================================================
//  Module      : sram_1r1w_strb
//  Description : Simple-dual-port RAM with byte strobes, registered read and a
//                post-reset clear sequencer. Define RAM_BYPASS_EN for
//                write-first behaviour on same-address read/write.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_1r1w_strb #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_1r1w_strb_if.slave      bus
);
    localparam int                ADDR_W      = $clog2(DEPTH);
    localparam int                c_NUM_LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic                  w_init_busy;
    logic [ADDR_W-1:0]     r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  w_rd_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_CLEAR && r_clr_cnt == c_LAST_ADDR) begin
            w_state_nxt = S_READY;
        end
    end

    always_comb begin
        w_init_busy = (r_state == S_CLEAR);
    end

    // Counter wraps to zero on the final clear write, leaving it ready for the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (w_init_busy) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_init_busy) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (bus.wen) begin
                for (int i = 0; i < c_NUM_LANES; i++) begin
                    if (bus.wstrb[i]) begin
                        r_mem[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
                    end
                end
            end
        end
    end

`ifdef RAM_BYPASS_EN
    logic w_hit;
    assign w_hit = bus.wen && (bus.waddr == bus.raddr);

    // Write-first: strobed lanes of a colliding write are forwarded to the read.
    generate
        for (genvar g = 0; g < c_NUM_LANES; g++) begin : g_bypass
            assign w_rd_word[8*g +: 8] = (w_hit && bus.wstrb[g]) ?
                                         bus.wdata[8*g +: 8] :
                                         r_mem[bus.raddr][8*g +: 8];
        end
    endgenerate
`else
    assign w_rd_word = r_mem[bus.raddr];
`endif

    assign w_rd_fire = bus.ren && !w_init_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd_fire;
            if (w_rd_fire) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    assign bus.init_busy = w_init_busy;
    assign bus.rdata     = r_rdata;
    assign bus.rvalid    = r_rvalid;
endmodule
`default_nettype wire

// File: tb/tb_sram_1r1w_strb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_1r1w_strb
//  Description : Self-checking bench: vector table, directed sequences and a
//                randomized run against an array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_1r1w_strb;
    localparam int DW = 64;
    localparam int DP = 64;
`ifdef RAM_BYPASS_EN
    localparam logic [63:0] c_COLL = 64'hDEADBEEF00000000;
`else
    localparam logic [63:0] c_COLL = 64'h0;
`endif

    typedef struct {
        logic        ren;
        logic [5:0]  raddr;
        logic        wen;
        logic [5:0]  waddr;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
        logic        exp_rvalid;
        logic [63:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [63:0] model_mem [DP];
    logic [63:0] exp_rdata;
    logic        exp_rvalid;
    vec_t        vecs [10];

    sram_1r1w_strb_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    sram_1r1w_strb #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one READY-state cycle and keeps the reference model in step.
    task automatic step(input logic r, input logic [5:0] ra, input logic w,
                        input logic [5:0] wa, input logic [7:0] ws, input logic [63:0] wd);
        logic [63:0] word;
        bus.ren = r; bus.raddr = ra; bus.wen = w; bus.waddr = wa; bus.wstrb = ws; bus.wdata = wd;
        exp_rvalid = r;
        if (r) begin
            word = model_mem[ra];
`ifdef RAM_BYPASS_EN
            if (w && wa == ra)
                for (int b = 0; b < 8; b++)
                    if (ws[b]) word[8*b +: 8] = wd[8*b +: 8];
`endif
            exp_rdata = word;
        end
        tick();
        if (w)
            for (int b = 0; b < 8; b++)
                if (ws[b]) model_mem[wa][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic idle();
        bus.ren = 1'b0; bus.wen = 1'b0; bus.wstrb = '0;
    endtask

    initial begin
        int cnt;
        logic [5:0] ra, wa;

        vecs[0] = '{1'b0, 6'd0, 1'b1, 6'd5, 8'hFF, 64'h1122334455667788, 1'b0, 64'h0};
        vecs[1] = '{1'b0, 6'd0, 1'b1, 6'd5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 64'h0};
        vecs[2] = '{1'b1, 6'd5, 1'b0, 6'd0, 8'h00, 64'h0, 1'b1, 64'h11223344AAAAAAAA};
        vecs[3] = '{1'b0, 6'd0, 1'b1, 6'd3, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h11223344AAAAAAAA};
        vecs[4] = '{1'b1, 6'd3, 1'b1, 6'd3, 8'hF0, 64'hDEADBEEF00000000, 1'b1, c_COLL};
        vecs[5] = '{1'b1, 6'd3, 1'b0, 6'd0, 8'h00, 64'h0, 1'b1, 64'hDEADBEEF00000000};
        vecs[6] = '{1'b0, 6'd0, 1'b0, 6'd0, 8'h00, 64'h0, 1'b0, 64'hDEADBEEF00000000};
        vecs[7] = '{1'b1, 6'd5, 1'b1, 6'd6, 8'hFF, 64'h0123456789ABCDEF, 1'b1, 64'h11223344AAAAAAAA};
        vecs[8] = '{1'b1, 6'd6, 1'b0, 6'd0, 8'h00, 64'h0, 1'b1, 64'h0123456789ABCDEF};
        vecs[9] = '{1'b1, 6'd4, 1'b1, 6'd4, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0};

        bus.raddr = '0; bus.waddr = '0; bus.wdata = '0;
        idle();
        for (int i = 0; i < DP; i++) model_mem[i] = '0;
        exp_rdata = '0;
        exp_rvalid = 1'b0;

        // Reset, then clear with a request injected at clear cycle 10.
        rst = 1'b1;
        tick(); tick();
        check("reset_busy", {63'b0, bus.init_busy}, 64'd1);
        check("reset_rvalid", {63'b0, bus.rvalid}, 64'd0);
        check("reset_rdata", bus.rdata, 64'h0);
        rst = 1'b0;
        cnt = 0;
        while (bus.init_busy && cnt < 200) begin
            if (cnt == 10) begin
                bus.ren = 1'b1; bus.raddr = 6'd7;
                bus.wen = 1'b1; bus.waddr = 6'd7; bus.wstrb = 8'hFF; bus.wdata = '1;
            end
            tick();
            idle();
            cnt++;
            if (bus.rvalid !== 1'b0) check("clear_rvalid", {63'b0, bus.rvalid}, 64'd0);
            if (bus.rdata !== 64'h0) check("clear_rdata", bus.rdata, 64'h0);
        end
        check("clear_cycles", 64'(cnt), 64'd64);

        // Every address reads back zero, including the one written during clear.
        for (int a = 0; a < DP; a++) begin
            step(1'b1, 6'(a), 1'b0, 6'd0, 8'h00, 64'h0);
            check($sformatf("zero_rvalid_%0d", a), {63'b0, bus.rvalid}, 64'd1);
            check($sformatf("zero_rdata_%0d", a), bus.rdata, 64'h0);
        end
        step(1'b0, 6'd0, 1'b0, 6'd0, 8'h00, 64'h0);
        check("zero_rvalid_drop", {63'b0, bus.rvalid}, 64'd0);

        for (int v = 0; v < 10; v++) begin
            step(vecs[v].ren, vecs[v].raddr, vecs[v].wen, vecs[v].waddr, vecs[v].wstrb, vecs[v].wdata);
            check($sformatf("vec%0d_rvalid", v), {63'b0, bus.rvalid}, {63'b0, vecs[v].exp_rvalid});
            check($sformatf("vec%0d_rdata", v), bus.rdata, vecs[v].exp_rdata);
        end

        // Streaming: fill addr i with i, then read back-to-back.
        for (int a = 0; a < DP; a++) step(1'b0, 6'd0, 1'b1, 6'(a), 8'hFF, 64'(a));
        for (int a = 0; a < DP; a++) begin
            step(1'b1, 6'(a), 1'b0, 6'd0, 8'h00, 64'h0);
            check($sformatf("stream_rvalid_%0d", a), {63'b0, bus.rvalid}, 64'd1);
            check($sformatf("stream_rdata_%0d", a), bus.rdata, 64'(a));
        end
        step(1'b0, 6'd0, 1'b0, 6'd0, 8'h00, 64'h0);
        check("stream_rvalid_drop", {63'b0, bus.rvalid}, 64'd0);
        check("stream_rdata_hold", bus.rdata, 64'd63);

        // Randomized traffic against the model; collisions are deliberately frequent.
        for (int n = 0; n < 600; n++) begin
            ra = 6'($urandom_range(0, DP - 1));
            wa = ($urandom_range(0, 3) == 0) ? ra : 6'($urandom_range(0, DP - 1));
            step(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                 8'($urandom), {$urandom, $urandom});
            check("rand_rvalid", {63'b0, bus.rvalid}, {63'b0, exp_rvalid});
            check("rand_rdata", bus.rdata, exp_rdata);
        end
        idle();

        // Reset pulsed at clear cycle 30 restarts the full clear.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 30; c++) tick();
        check("midclear_busy", {63'b0, bus.init_busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midclear_rst_rdata", bus.rdata, 64'h0);
        cnt = 0;
        while (bus.init_busy && cnt < 200) begin
            tick();
            cnt++;
        end
        check("midclear_cycles", 64'(cnt), 64'd64);
        step(1'b1, 6'd63, 1'b0, 6'd0, 8'h00, 64'h0);
        check("midclear_read_rvalid", {63'b0, bus.rvalid}, 64'd1);
        check("midclear_read_rdata", bus.rdata, 64'h0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
